mem_port_arbiter: RTL and testbench

Two-requester arbiter that shares the single unified instruction/data memory between the multi-cycle CPU and a debug/loader port. The CPU owns the memory by default. A debug request is granted either when the CPU leaves the bus idle or after a bounded starvation window. While the debug port owns the memory, `cpu_stall` freezes the CPU's state-advancing writes (PC, IR, register file, controller state).

---
 rtl/mem_port_arbiter.sv | 149 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one unified instruction/data memory between the
// multi-cycle CPU (default owner) and a debug/loader port. Debug gets the bus
// when the CPU is idle or after a bounded starvation window; while debug owns
// the bus the CPU is stalled.
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  input  logic              dbg_lock,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [1:0] ST_CPU    = 2'd0;
  localparam logic [1:0] ST_SWITCH = 2'd1;
  localparam logic [1:0] ST_DBG    = 2'd2;

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  // Counter value on the last contended cycle the CPU is allowed to win.
  localparam logic [CNT_W-1:0] STARVE_LAST = CNT_W'(STARVE_LIMIT - 1);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [CNT_W-1:0]  starve_cnt_r;
  logic [CNT_W-1:0]  starve_cnt_nxt_s;
  logic [DATA_W-1:0] dbg_rdata_r;
  logic              dbg_rvalid_r;
  logic              in_cpu_s;
  logic              in_dbg_s;
  logic              cpu_gnt_s;
  logic              dbg_gnt_s;
  logic              dbg_rd_s;

  // Owner decode straight from the state register so the stall is glitch-free.
  assign in_cpu_s  = (state_r == ST_CPU);
  assign in_dbg_s  = (state_r == ST_DBG);
  assign cpu_gnt_s = in_cpu_s & cpu_req;
  assign dbg_gnt_s = in_dbg_s & dbg_req;
  assign dbg_rd_s  = dbg_gnt_s & ~dbg_we;

  assign cpu_gnt    = cpu_gnt_s;
  assign dbg_gnt    = dbg_gnt_s;
  assign cpu_stall  = (state_r == ST_SWITCH) | in_dbg_s;
  assign cpu_rdata  = mem_rdata;
  assign dbg_rdata  = dbg_rdata_r;
  assign dbg_rvalid = dbg_rvalid_r;

  // Memory-side mux: the owner drives address/data, strobes only on a grant.
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    if (in_dbg_s) begin
      mem_addr  = dbg_addr;
      mem_wdata = dbg_wdata;
    end else begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
    mem_read  = (cpu_gnt_s & ~cpu_we) | (dbg_gnt_s & ~dbg_we);
    // Writes are blocked while reset is held so nothing corrupts memory.
    mem_write = reset & ((cpu_gnt_s & cpu_we) | (dbg_gnt_s & dbg_we));
  end

  // Next-state and starvation-counter decode.
  always_comb begin
    state_nxt_s      = state_r;
    starve_cnt_nxt_s = starve_cnt_r;
    case (state_r)
      ST_CPU: begin
        if (dbg_req & (~cpu_req | (starve_cnt_r == STARVE_LAST))) begin
          state_nxt_s = ST_SWITCH;
        end else begin
          state_nxt_s = ST_CPU;
        end
        if (!dbg_req) begin
          starve_cnt_nxt_s = '0;
        end else if (cpu_req) begin
          starve_cnt_nxt_s = starve_cnt_r + CNT_W'(1);
        end else begin
          starve_cnt_nxt_s = starve_cnt_r;
        end
      end
      ST_SWITCH: begin
        state_nxt_s      = ST_DBG;
        starve_cnt_nxt_s = '0;
      end
      ST_DBG: begin
        // Without lock, one access (or a withdrawn request) hands the bus back.
        if (!dbg_lock && (dbg_gnt_s || !dbg_req)) begin
          state_nxt_s = ST_CPU;
        end else begin
          state_nxt_s = ST_DBG;
        end
        starve_cnt_nxt_s = '0;
      end
      default: begin
        state_nxt_s      = ST_CPU;
        starve_cnt_nxt_s = '0;
      end
    endcase
  end

  // Ownership state and starvation counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_CPU;
      starve_cnt_r <= '0;
    end else begin
      state_r      <= state_nxt_s;
      starve_cnt_r <= starve_cnt_nxt_s;
    end
  end

  // Debug read capture; rvalid pulses the cycle after a granted read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dbg_rdata_r  <= '0;
      dbg_rvalid_r <= 1'b0;
    end else begin
      dbg_rvalid_r <= dbg_rd_s;
      if (dbg_rd_s) begin
        dbg_rdata_r <= mem_rdata;
      end else begin
        dbg_rdata_r <= dbg_rdata_r;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed testbench for mem_port_arbiter with a small word memory model.
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic        cpu_gnt;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic        dbg_req;
  logic        dbg_we;
  logic [31:0] dbg_addr;
  logic [31:0] dbg_wdata;
  logic        dbg_lock;
  logic        dbg_gnt;
  logic [31:0] dbg_rdata;
  logic        dbg_rvalid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  logic [31:0] mem_q [0:255];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_data;

  int vec_cnt;
  int miscompares;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(8)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_read(mem_read),
    .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Combinational read, write committed at the rising edge.
  assign mem_rdata = mem_q[mem_addr[9:2]];

  // Memory model: bench preload port has priority over DUT writes.
  always @(posedge clk) begin
    if (pre_we) mem_q[pre_idx] <= pre_data;
    else if (mem_write) mem_q[mem_addr[9:2]] <= mem_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    pre_we   = 1'b1;
    pre_idx  = addr[9:2];
    pre_data = data;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  int grants;
  int stalls;
  bit seen_dbg;

  initial begin
    vec_cnt = 0; miscompares = 0;
    pre_we = 1'b0; pre_idx = 8'd0; pre_data = 32'd0;
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h0000_0300; cpu_wdata = 32'hBAD0_BAD0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'd0; dbg_wdata = 32'd0; dbg_lock = 1'b0;

    // Reset state; CPU write presented but must not strobe during reset.
    preload(32'h40, 32'hDEAD_BEEF);
    preload(32'h300, 32'h1234_5678);
    preload(32'h200, 32'h0000_0000);
    @(negedge clk); #1;
    chk("rst_stall",  32'(cpu_stall),  32'd0);
    chk("rst_dgnt",   32'(dbg_gnt),    32'd0);
    chk("rst_rvalid", 32'(dbg_rvalid), 32'd0);
    chk("rst_rdata",  dbg_rdata,       32'd0);
    chk("rst_mwrite", 32'(mem_write),  32'd0);
    chk("rst_cgnt",   32'(cpu_gnt),    32'd1);
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Idle-bus debug read of 0x40.
    @(negedge clk);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40; #1;
    chk("rd_c1_stall", 32'(cpu_stall), 32'd0);
    chk("rd_c1_dgnt",  32'(dbg_gnt),   32'd0);
    @(negedge clk); #1;
    chk("rd_c2_stall", 32'(cpu_stall), 32'd1);
    chk("rd_c2_dgnt",  32'(dbg_gnt),   32'd0);
    chk("rd_c2_mread", 32'(mem_read),  32'd0);
    @(negedge clk); #1;
    chk("rd_c3_dgnt",  32'(dbg_gnt),   32'd1);
    chk("rd_c3_stall", 32'(cpu_stall), 32'd1);
    chk("rd_c3_mread", 32'(mem_read),  32'd1);
    chk("rd_c3_maddr", mem_addr,       32'h40);
    @(negedge clk);
    dbg_req = 1'b0; #1;
    chk("rd_c4_rvalid", 32'(dbg_rvalid), 32'd1);
    chk("rd_c4_rdata",  dbg_rdata,       32'hDEAD_BEEF);
    chk("rd_c4_stall",  32'(cpu_stall),  32'd0);
    @(negedge clk); #1;
    chk("rd_c5_rvalid", 32'(dbg_rvalid), 32'd0);

    // Starvation: CPU busy every cycle, debug read pending.
    grants = 0; stalls = 0; seen_dbg = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0;
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      if (seen_dbg) dbg_req = 1'b0;
      #1;
      if (cpu_gnt && !seen_dbg && dbg_req) grants++;
      if (cpu_stall) stalls++;
      if (dbg_gnt) seen_dbg = 1'b1;
    end
    chk("starve_cpu_grants", 32'(grants),   32'd8);
    chk("starve_stalls",     32'(stalls),   32'd2);
    chk("starve_dbg_seen",   32'(seen_dbg), 32'd1);
    cpu_req = 1'b0;

    // Locked burst of three writes.
    @(negedge clk);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_lock = 1'b1;
    dbg_addr = 32'h100; dbg_wdata = 32'h11;
    @(negedge clk);
    @(negedge clk); #1;
    chk("burst_g0",  32'(dbg_gnt),   32'd1);
    chk("burst_w0",  32'(mem_write), 32'd1);
    @(negedge clk);
    dbg_addr = 32'h104; dbg_wdata = 32'h22; #1;
    chk("burst_g1",  32'(dbg_gnt),   32'd1);
    @(negedge clk);
    dbg_addr = 32'h108; dbg_wdata = 32'h33; dbg_lock = 1'b0; #1;
    chk("burst_g2",  32'(dbg_gnt),   32'd1);
    chk("burst_a2",  mem_addr,       32'h108);
    @(negedge clk);
    dbg_req = 1'b0; dbg_we = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100; #1;
    chk("burst_ret_stall", 32'(cpu_stall), 32'd0);
    chk("burst_rb0", cpu_rdata, 32'h11);
    cpu_addr = 32'h104; #1;
    chk("burst_rb1", cpu_rdata, 32'h22);
    cpu_addr = 32'h108; #1;
    chk("burst_rb2", cpu_rdata, 32'h33);
    @(negedge clk);
    cpu_req = 1'b0;

    // Debug write isolation against a stalled CPU write to the same word.
    @(negedge clk);
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h200; dbg_wdata = 32'hDB00_00DB;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h200; cpu_wdata = 32'hC0FF_EE00; #1;
    chk("iso_sw_cgnt",  32'(cpu_gnt),   32'd0);
    chk("iso_sw_mwr",   32'(mem_write), 32'd0);
    @(negedge clk); #1;
    chk("iso_dbg_cgnt", 32'(cpu_gnt),   32'd0);
    chk("iso_dbg_wd",   mem_wdata,      32'hDB00_00DB);
    @(negedge clk);
    dbg_req = 1'b0; dbg_we = 1'b0; #1;
    chk("iso_mem_dbg",  mem_q[8'h80],   32'hDB00_00DB);
    chk("iso_cgnt",     32'(cpu_gnt),   32'd1);
    chk("iso_cwd",      mem_wdata,      32'hC0FF_EE00);
    @(negedge clk);
    cpu_req = 1'b0; cpu_we = 1'b0; #1;
    chk("iso_mem_cpu",  mem_q[8'h80],   32'hC0FF_EE00);

    // Reset while in a locked debug burst with a read outstanding.
    @(negedge clk);
    dbg_req = 1'b1; dbg_we = 1'b0; dbg_lock = 1'b1; dbg_addr = 32'h40;
    @(negedge clk);
    @(negedge clk); #1;
    chk("rb_dgnt", 32'(dbg_gnt), 32'd1);
    @(negedge clk);
    dbg_we = 1'b1; dbg_addr = 32'h300; dbg_wdata = 32'h5555_5555;
    reset = 1'b0; #1;
    chk("rb_rst_stall",  32'(cpu_stall),  32'd0);
    chk("rb_rst_rvalid", 32'(dbg_rvalid), 32'd0);
    chk("rb_rst_rdata",  dbg_rdata,       32'd0);
    chk("rb_rst_mwr",    32'(mem_write),  32'd0);
    @(negedge clk);
    reset = 1'b1; dbg_req = 1'b0; dbg_lock = 1'b0; dbg_we = 1'b0; #1;
    chk("rb_rel_stall",  32'(cpu_stall),  32'd0);
    chk("rb_rel_mwr",    32'(mem_write),  32'd0);
    chk("rb_rel_rvalid", 32'(dbg_rvalid), 32'd0);
    @(negedge clk); #1;
    chk("rb_mem300",     mem_q[8'hC0],    32'h1234_5678);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

endmodule
